// File: rtl/btn_pkg.sv
// Shared constants for the controller button front end: channel indices and
// default timing derived from the 50 MHz system clock.
package btn_pkg;

  localparam int BTN_GREEN  = 0;
  localparam int BTN_RED    = 1;
  localparam int BTN_BLUE   = 2;
  localparam int BTN_YELLOW = 3;

  localparam int SYS_CLK_HZ = 50_000_000;

  // 1 ms debounce window and 1 s long-hold threshold.
  localparam int DEFAULT_DEBOUNCE_CYCLES = SYS_CLK_HZ / 1000;
  localparam int DEFAULT_HOLD_CYCLES     = SYS_CLK_HZ;

endpackage

// File: rtl/button_debounce_channel.sv
// One button channel: polarity fix, synchroniser, counter debounce,
// registered press/release pulses and a single-shot long-hold pulse.
module button_debounce_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold,
  output logic o_press_set
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic              POL      = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic                   r_stable;
  logic                   r_press;
  logic                   r_release;
  logic                   r_hold;

  logic w_pressed;
  logic w_sync;
  logic w_differs;
  logic w_accept;

  // Polarity is normalised before the first flop so everything downstream
  // sees 1 = pressed.
  assign w_pressed = i_btn_raw ^ POL;
  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_sync != r_stable);
  assign w_accept  = w_differs && (r_db_cnt == DB_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= '0;
      r_db_cnt  <= '0;
      r_stable  <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], w_pressed};
      r_press   <= w_accept && w_sync;
      r_release <= w_accept && !w_sync;
      if (!w_differs || w_accept) begin
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
      if (w_accept) begin
        r_stable <= w_sync;
      end
    end
  end

  // Hold counter saturates at HOLD_MAX so the pulse fires once per press.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_cnt <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_hold <= r_stable && (r_hold_cnt == HOLD_PRE);
      if (!r_stable) begin
        r_hold_cnt <= '0;
      end else if (r_hold_cnt != HOLD_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign o_level     = r_stable;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_hold      = r_hold;
  assign o_press_set = w_accept && w_sync;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: NUM_BTNS independent debounce channels
// plus a registered any_press pulse aligned with btn_press.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTNS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_hold,
  output logic                any_press
);

  logic [NUM_BTNS-1:0] w_press_set;
  logic                r_any_press;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    button_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_btn_raw  (btn_raw[g]),
      .o_level    (btn_level[g]),
      .o_press    (btn_press[g]),
      .o_release  (btn_release[g]),
      .o_hold     (btn_hold[g]),
      .o_press_set(w_press_set[g])
    );
  end

  // Registered from the channels' pre-register press terms so it lands on
  // the same edge as btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_any_press <= 1'b0;
    end else begin
      r_any_press <= |w_press_set;
    end
  end

  assign any_press = r_any_press;

endmodule
